adc_scan_seq: RTL and testbench
===============================

// Module: adc_scan_seq
// PURPOSE
//   Autonomous multi-channel scanner for ADC082S021/ADC122S021-class SPI ADCs. Owns the SPI
//   bus: generates ss_n/sclk/mosi, walks an enabled-channel mask and compensates for the
//   ADC's one-frame pipeline latency. Emits tagged samples on a valid/ready stream.
//   Sits between the ADC pins and the sample FIFO/register bank.
// PARAMETERS
//   NCHAN    8   number of ADC inputs, 1..8; address field is always 3 bits
//   RES_BITS 12  result width; sample_data = rx[11 -: RES_BITS] (8 for 082, 12 for 122)
//   CLKDIV   4   sclk half-period in clk cycles, >=1
//   IDLE_CYC 8   ss_n high time between scans in clk cycles, >=1
// PORTS
//   clk          in   1         system clock
//   reset        in   1         synchronous, active-high
//   start        in   1         begin a scan (level; sampled in IDLE only)
//   continuous   in   1         1 = rescan after each gap; sampled at end of each scan
//   chan_mask    in   NCHAN     enabled channels; latched at scan start
//   busy         out  1         1 from leaving IDLE until return to IDLE
//   scan_done    out  1         1-cycle pulse when the last sample of a scan is produced
//   sample_valid out  1         output holds a sample
//   sample_ready in   1         consumer accepts when valid&ready
//   sample_chan  out  3         channel number of sample_data
//   sample_data  out  RES_BITS  conversion result
//   overrun      out  1         sticky: a sample was dropped
//   overrun_clr  in   1         clears overrun
//   ss_n         out  1         ADC chip select, active low
//   sclk         out  1         SPI clock, idles high
//   mosi         out  1         SPI data to ADC
//   miso         in   1         SPI data from ADC (synchronised externally)
// BEHAVIOUR
//   Reset (also mid-frame): state IDLE, ss_n=1, sclk=1, mosi=0, busy=0, scan_done=0,
//     sample_valid=0, sample_chan=0, sample_data=0, overrun=0. Partial frame abandoned.
//   States: IDLE -> SETUP -> SHIFT -> (SHIFT | GAP) -> (SETUP | IDLE).
//   IDLE: if start && |chan_mask: latch mask, build list L = enabled channels ascending
//     (n entries), ss_n<=0, busy<=1, go SETUP. start with mask==0 is ignored.
//   SETUP: CLKDIV cycles with ss_n low and sclk high, then SHIFT.
//   Frame = 16 bits MSB first. TX word = {2'b00, addr[2:0], 11'b0}.
//     Per bit: sclk low CLKDIV cycles, then high CLKDIV cycles.
//     mosi updates on the clk edge that drives sclk low.
//     miso is shifted into rx on the edge that drives sclk high.
//   Scan = n+1 back-to-back frames, ss_n held low throughout with no gap between frames.
//     Frame k (0..n-1) addresses L[k]; frame n re-addresses L[0] (dummy).
//     Frame 0 rx is discarded. Frame k>=1 rx is the result for L[k-1].
//   Result publish happens one cycle after the 16th sampling edge.
//     If !sample_valid, or valid&ready in the same cycle: load chan/data, sample_valid=1.
//     Else the new sample is dropped and overrun<=1.
//     overrun_clr with a simultaneous drop: overrun stays 1 (set wins).
//   scan_done pulses in the cycle the frame-n result is published, even if it was dropped.
//   After frame n: sclk=1, ss_n<=1, GAP for IDLE_CYC cycles.
//     Then, if continuous && |chan_mask: relatch mask, ss_n<=0, go SETUP.
//     Otherwise go IDLE with busy<=0.
//   Dropping continuous mid-scan: the current scan completes, then IDLE.
//   mask changes mid-scan take effect only at the next scan start.
//   sample_valid falls the cycle after valid&ready unless a new sample loads in that cycle.
//   Frame length is 32*CLKDIV clk cycles.
//   Scan length is CLKDIV + (n+1)*32*CLKDIV + IDLE_CYC clk cycles.
// TESTING
//   1 Single scan: mask=8'h05, CLKDIV=2; ADC model returns 12'h100+addr delayed one frame.
//     -> 3 frames / 48 sclk rises with ss_n low.
//     -> mosi addr sequence 0,2,0.
//     -> samples (0,12'h100), (2,12'h102).
//     -> scan_done with the second sample; busy=0 after IDLE_CYC.
//   2 Backpressure: sample_ready=0, mask=8'h07.
//     -> first sample (ch0) held.
//     -> ch1 and ch2 dropped; overrun=1.
//     -> overrun_clr in the same cycle as a drop leaves overrun=1.
//   3 Continuous: continuous=1, mask=8'h80, held 3 scans.
//     -> 3 x (2 frames + IDLE_CYC ss_n-high gap), samples chan 7.
//     -> deassert during scan 3 -> IDLE after it, no 4th scan.
//   4 Mask edge: start with mask=0 -> busy stays 0, ss_n=1.
//     mask changed mid-scan -> current scan addresses old list; next scan uses new list.
//   5 Reset mid-frame: assert reset at bit 7 of frame 1.
//     -> next cycle ss_n=1, sclk=1, sample_valid=0, overrun=0.
//     -> restart yields correct ch0 data.
//   6 RES_BITS=8: rx=16'h0ABC -> sample_data=8'hAB.

Source files
------------

// File: rtl/adc_scan_seq.sv
// Autonomous scanner for ADC082S021/ADC122S021-class SPI ADCs: drives the SPI pins,
// walks the enabled-channel list and emits tagged samples on a valid/ready stream.
module adc_scan_seq #(
  parameter int NCHAN    = 8,
  parameter int RES_BITS = 12,
  parameter int CLKDIV   = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic [NCHAN-1:0]    chan_mask,
  output logic                busy,
  output logic                scan_done,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [2:0]          sample_chan,
  output logic [RES_BITS-1:0] sample_data,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                ss_n,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso
);

  localparam int CNT_MAX = (CLKDIV > IDLE_CYC) ? CLKDIV : IDLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_CYC - 1);
  // Result bits rx[11 -: RES_BITS] arrive on frame bits 4 .. 3+RES_BITS.
  localparam logic [3:0]    RX_FIRST  = 4'd4;
  localparam logic [3:0]    RX_LAST   = 4'(3 + RES_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP} state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [3:0]          bit_r;
  logic [3:0]          frame_r;
  logic [3:0]          nlast_r;
  logic [2:0]          list_r [0:7];
  logic [RES_BITS-1:0] rx_r;
  logic                pend_r;
  logic [2:0]          pend_chan_r;
  logic                pend_last_r;

  logic [2:0]          list_s [0:7];
  logic [3:0]          n_s;
  logic [2:0]          cur_addr_s;
  logic [15:0]         tx_s;

  function automatic logic [15:0] tx_word(input logic [2:0] addr);
    return {2'b00, addr, 11'b0};
  endfunction

  // Compact the enabled channels into an ascending list; n_s is its length.
  always_comb begin
    list_s = '{default: 3'd0};
    n_s    = 4'd0;
    for (int i = 0; i < NCHAN; i++) begin
      if (chan_mask[i]) begin
        list_s[n_s[2:0]] = 3'(i);
        n_s              = n_s + 4'd1;
      end else begin
        n_s = n_s;
      end
    end
  end

  // Address of the frame in flight; the final frame is a dummy re-read of L[0].
  always_comb begin
    if (frame_r == nlast_r) begin
      cur_addr_s = list_r[0];
    end else begin
      cur_addr_s = list_r[frame_r[2:0]];
    end
    tx_s = tx_word(cur_addr_s);
  end

  // Scan sequencer, SPI shifter and output stream register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      bit_r        <= 4'd0;
      frame_r      <= 4'd0;
      nlast_r      <= 4'd0;
      list_r       <= '{default: 3'd0};
      rx_r         <= '0;
      pend_r       <= 1'b0;
      pend_chan_r  <= 3'd0;
      pend_last_r  <= 1'b0;
      ss_n         <= 1'b1;
      sclk         <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
      sample_valid <= 1'b0;
      sample_chan  <= 3'd0;
      sample_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      pend_r    <= 1'b0;
      if (overrun_clr) begin
        overrun <= 1'b0;
      end
      // A drop in the same cycle as overrun_clr must leave overrun set.
      if (pend_r) begin
        scan_done <= pend_last_r;
        if (!sample_valid || sample_ready) begin
          sample_valid <= 1'b1;
          sample_chan  <= pend_chan_r;
          sample_data  <= rx_r;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (start && (|chan_mask)) begin
            list_r  <= list_s;
            nlast_r <= n_s;
            frame_r <= 4'd0;
            ss_n    <= 1'b0;
            busy    <= 1'b1;
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r != DIV_LAST) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            cnt_r   <= '0;
            bit_r   <= 4'd0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;  // bit 15 of every TX word is zero
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_r != DIV_LAST) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            cnt_r <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (bit_r >= RX_FIRST && bit_r <= RX_LAST) begin
                rx_r <= {rx_r[RES_BITS-2:0], miso};
              end
              if (bit_r == 4'd15) begin
                pend_r      <= (frame_r != 4'd0);
                pend_chan_r <= list_r[frame_r[2:0] - 3'd1];
                pend_last_r <= (frame_r == nlast_r);
              end
            end else if (bit_r != 4'd15) begin
              bit_r <= bit_r + 4'd1;
              sclk  <= 1'b0;
              mosi  <= tx_s[4'd14 - bit_r];
            end else if (frame_r == nlast_r) begin
              ss_n    <= 1'b1;
              state_r <= ST_GAP;
            end else begin
              frame_r <= frame_r + 4'd1;
              bit_r   <= 4'd0;
              sclk    <= 1'b0;
              mosi    <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (cnt_r != GAP_LAST) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            cnt_r <= '0;
            if (continuous && (|chan_mask)) begin
              list_r  <= list_s;
              nlast_r <= n_s;
              frame_r <= 4'd0;
              ss_n    <= 1'b0;
              state_r <= ST_SETUP;
            end else begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ss_n    <= 1'b1;
          sclk    <= 1'b1;
          mosi    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq with a behavioural ADC122S021-style pipeline model.
module tb_adc_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start8, continuous, sample_ready, overrun_clr, miso;
  logic [7:0] chan_mask;
  logic busy, scan_done, sample_valid, overrun, ss_n, sclk, mosi;
  logic [2:0] sample_chan;
  logic [11:0] sample_data;
  logic busy8, scan_done8, sample_valid8, overrun8, ss_n8, sclk8, mosi8;
  logic [2:0] sample_chan8;
  logic [7:0] sample_data8;

  adc_scan_seq #(.NCHAN(8), .RES_BITS(12), .CLKDIV(2), .IDLE_CYC(8)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .chan_mask(chan_mask),
    .busy(busy), .scan_done(scan_done), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_chan(sample_chan), .sample_data(sample_data), .overrun(overrun),
    .overrun_clr(overrun_clr), .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso));

  adc_scan_seq #(.NCHAN(8), .RES_BITS(8), .CLKDIV(2), .IDLE_CYC(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .continuous(continuous), .chan_mask(chan_mask),
    .busy(busy8), .scan_done(scan_done8), .sample_valid(sample_valid8), .sample_ready(sample_ready),
    .sample_chan(sample_chan8), .sample_data(sample_data8), .overrun(overrun8),
    .overrun_clr(overrun_clr), .ss_n(ss_n8), .sclk(sclk8), .mosi(mosi8), .miso(miso));

  // ADC model: returns {4'h0, 12'h100+addr} of the previous frame, shifted on sclk rises.
  logic sel8 = 1'b0, force_en = 1'b0;
  logic [15:0] force_word = 16'h0000;
  logic m_ss_n, m_sclk, m_mosi;
  assign m_ss_n = sel8 ? ss_n8 : ss_n;
  assign m_sclk = sel8 ? sclk8 : sclk;
  assign m_mosi = sel8 ? mosi8 : mosi;
  logic sel_r = 1'b1;
  logic [15:0] adc_sh = 16'h0000, cap = 16'h0000;
  int adc_bits = 0, m_frames = 0, rises = 0;
  logic [2:0] addr_q [$];
  assign miso = adc_sh[15];

  always @(posedge m_sclk or negedge m_ss_n or posedge m_ss_n) begin
    if (m_ss_n) begin
      sel_r = 1'b1;
    end else if (sel_r) begin
      sel_r = 1'b0; adc_bits = 0; m_frames = 0; adc_sh = 16'h0FFF;
    end else begin
      cap = {cap[14:0], m_mosi}; adc_sh = {adc_sh[14:0], 1'b0};
      adc_bits++; rises++;
      if (adc_bits == 16) begin
        adc_bits = 0; m_frames++;
        addr_q.push_back(cap[13:11]);
        adc_sh = force_en ? force_word : {4'h0, 12'h100 + {9'd0, cap[13:11]}};
      end
    end
  end

  logic [14:0] samp_q [$];
  int done_cnt = 0, busy_cyc = 0, gap_cyc = 0;
  logic [2:0] done_chan = 3'd0;
  // Stream / status monitor for the 12-bit instance.
  always @(negedge clk) begin
    if (!sel8) begin
      if (sample_valid && sample_ready) samp_q.push_back({sample_chan, sample_data});
      if (scan_done) begin done_cnt++; done_chan = sample_chan; end
      if (busy) busy_cyc++;
      if (busy && ss_n) gap_cyc++;
    end
  end

  int tests_run, failed;
  int a_base, s_base, d_base, b_base, g_base, r_base;

  task automatic mark();
    a_base = addr_q.size(); s_base = samp_q.size(); d_base = done_cnt;
    b_base = busy_cyc; g_base = gap_cyc; r_base = rises;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk); chan_mask = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) begin tests_run++; failed++; $display("FAIL %s_idle_timeout: busy=%0b required 0", tag, busy); end
  endtask

  task automatic wait_frames(input int k, input string tag);
    int n = 0;
    while (m_frames < k && n < 3000) begin @(negedge clk); n++; end
    if (m_frames < k) begin tests_run++; failed++; $display("FAIL %s_frame_timeout: frames=%0d required %0d", tag, m_frames, k); end
  endtask

  task automatic wait_ss(input logic v, input string tag);
    int n = 0;
    while (ss_n !== v && n < 3000) begin @(negedge clk); n++; end
    if (ss_n !== v) begin tests_run++; failed++; $display("FAIL %s_ss_timeout: ss_n=%0b required %0b", tag, ss_n, v); end
  endtask

  task automatic wait_done(input int k, input string tag);
    int n = 0;
    while (done_cnt - d_base < k && n < 3000) begin @(negedge clk); n++; end
    if (done_cnt - d_base < k) begin tests_run++; failed++; $display("FAIL %s_done_timeout: done=%0d required %0d", tag, done_cnt - d_base, k); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ss_n, sclk, mosi, busy, scan_done, sample_valid, sample_chan, sample_data, overrun} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0}) begin
      failed++; $display("FAIL reset_state: got ss=%0b sclk=%0b mosi=%0b busy=%0b done=%0b v=%0b ch=%0d d=%h ov=%0b required 1 1 0 0 0 0 0 000 0",
        ss_n, sclk, mosi, busy, scan_done, sample_valid, sample_chan, sample_data, overrun);
    end
    tests_run++;
    if ({ss_n8, sclk8, busy8, sample_valid8, sample_data8} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failed++; $display("FAIL reset_state8: got ss=%0b sclk=%0b busy=%0b v=%0b d=%h", ss_n8, sclk8, busy8, sample_valid8, sample_data8);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_scan();
    logic [2:0]  exp_a [3] = '{3'd0, 3'd2, 3'd0};
    logic [14:0] exp_s [2] = '{{3'd0, 12'h100}, {3'd2, 12'h102}};
    mark();
    pulse_start(8'h05);
    wait_idle("single");
    @(negedge clk);
    tests_run++;
    if (rises - r_base != 48) begin failed++; $display("FAIL single_rises: got %0d required 48", rises - r_base); end
    tests_run++;
    if (addr_q.size() - a_base != 3) begin failed++; $display("FAIL single_nframes: got %0d required 3", addr_q.size() - a_base); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (addr_q[a_base+i] !== exp_a[i]) begin failed++; $display("FAIL single_addr[%0d]: got %0d required %0d", i, addr_q[a_base+i], exp_a[i]); end
    end
    tests_run++;
    if (samp_q.size() - s_base != 2) begin failed++; $display("FAIL single_nsamples: got %0d required 2", samp_q.size() - s_base); end
    else for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (samp_q[s_base+i] !== exp_s[i]) begin failed++; $display("FAIL single_sample[%0d]: got %h required %h", i, samp_q[s_base+i], exp_s[i]); end
    end
    tests_run++;
    if (done_cnt - d_base != 1 || done_chan !== 3'd2) begin failed++; $display("FAIL single_done: got count %0d chan %0d required 1 chan 2", done_cnt - d_base, done_chan); end
    tests_run++;
    if (gap_cyc - g_base != 8) begin failed++; $display("FAIL single_gap: got %0d required 8", gap_cyc - g_base); end
    tests_run++;
    if (busy_cyc - b_base != 202) begin failed++; $display("FAIL single_scan_len: got %0d required 202", busy_cyc - b_base); end
  endtask

  task automatic test_backpressure();
    mark();
    sample_ready = 1'b0;
    pulse_start(8'h07);
    wait_frames(2, "bp");
    @(negedge clk);
    tests_run++;
    if ({sample_valid, sample_chan, sample_data, overrun} !== {1'b1, 3'd0, 12'h100, 1'b0}) begin
      failed++; $display("FAIL bp_first: got v=%0b ch=%0d d=%h ov=%0b required 1 0 100 0", sample_valid, sample_chan, sample_data, overrun);
    end
    wait_frames(3, "bp");
    @(negedge clk);
    tests_run++;
    if ({sample_chan, sample_data, overrun} !== {3'd0, 12'h100, 1'b1}) begin
      failed++; $display("FAIL bp_drop1: got ch=%0d d=%h ov=%0b required 0 100 1", sample_chan, sample_data, overrun);
    end
    wait_frames(4, "bp");
    overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (overrun !== 1'b1) begin failed++; $display("FAIL bp_clr_vs_drop: got overrun %0b required 1", overrun); end
    tests_run++;
    if (done_cnt - d_base != 1) begin failed++; $display("FAIL bp_done_on_drop: got %0d required 1", done_cnt - d_base); end
    wait_idle("bp");
    tests_run++;
    if ({sample_valid, sample_chan, sample_data} !== {1'b1, 3'd0, 12'h100}) begin
      failed++; $display("FAIL bp_held: got v=%0b ch=%0d d=%h required 1 0 100", sample_valid, sample_chan, sample_data);
    end
    overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin failed++; $display("FAIL bp_clr: got overrun %0b required 0", overrun); end
    sample_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b0) begin failed++; $display("FAIL bp_drain: got valid %0b required 0", sample_valid); end
  endtask

  task automatic test_continuous();
    mark();
    continuous = 1'b1;
    pulse_start(8'h80);
    wait_done(2, "cont");
    wait_ss(1'b1, "cont");
    wait_ss(1'b0, "cont");
    continuous = 1'b0;
    wait_idle("cont");
    repeat (60) begin
      @(negedge clk);
      if (ss_n !== 1'b1 || busy !== 1'b0) break;
    end
    tests_run++;
    if (ss_n !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL cont_stop: got ss=%0b busy=%0b required 1 0", ss_n, busy); end
    tests_run++;
    if (done_cnt - d_base != 3) begin failed++; $display("FAIL cont_scans: got %0d required 3", done_cnt - d_base); end
    tests_run++;
    if (addr_q.size() - a_base != 6) begin failed++; $display("FAIL cont_frames: got %0d required 6", addr_q.size() - a_base); end
    tests_run++;
    if (samp_q.size() - s_base != 3) begin failed++; $display("FAIL cont_nsamples: got %0d required 3", samp_q.size() - s_base); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (samp_q[s_base+i] !== {3'd7, 12'h107}) begin failed++; $display("FAIL cont_sample[%0d]: got %h required %h", i, samp_q[s_base+i], {3'd7, 12'h107}); end
    end
    tests_run++;
    if (gap_cyc - g_base != 24) begin failed++; $display("FAIL cont_gaps: got %0d required 24", gap_cyc - g_base); end
    tests_run++;
    if (busy_cyc - b_base != 414) begin failed++; $display("FAIL cont_len: got %0d required 414", busy_cyc - b_base); end
  endtask

  task automatic test_mask_edge();
    logic [2:0]  exp_a [6] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2};
    logic [14:0] exp_s [4] = '{{3'd0, 12'h100}, {3'd1, 12'h101}, {3'd2, 12'h102}, {3'd3, 12'h103}};
    mark();
    @(negedge clk); chan_mask = 8'h00; start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || ss_n !== 1'b1 || rises != r_base) begin
      failed++; $display("FAIL mask0_ignored: got busy=%0b ss=%0b rises=%0d required 0 1 0", busy, ss_n, rises - r_base);
    end
    mark();
    continuous = 1'b1;
    pulse_start(8'h03);
    wait_frames(1, "mask");
    chan_mask = 8'h0C;
    wait_done(1, "mask");
    wait_ss(1'b1, "mask");
    wait_ss(1'b0, "mask");
    continuous = 1'b0;
    wait_idle("mask");
    @(negedge clk);
    tests_run++;
    if (addr_q.size() - a_base != 6) begin failed++; $display("FAIL mask_nframes: got %0d required 6", addr_q.size() - a_base); end
    else for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (addr_q[a_base+i] !== exp_a[i]) begin failed++; $display("FAIL mask_addr[%0d]: got %0d required %0d", i, addr_q[a_base+i], exp_a[i]); end
    end
    tests_run++;
    if (samp_q.size() - s_base != 4) begin failed++; $display("FAIL mask_nsamples: got %0d required 4", samp_q.size() - s_base); end
    else for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (samp_q[s_base+i] !== exp_s[i]) begin failed++; $display("FAIL mask_sample[%0d]: got %h required %h", i, samp_q[s_base+i], exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    sample_ready = 1'b0;
    pulse_start(8'h03);
    wait_idle("rst_pre");
    tests_run++;
    if (sample_valid !== 1'b1 || overrun !== 1'b1) begin failed++; $display("FAIL rst_precond: got v=%0b ov=%0b required 1 1", sample_valid, overrun); end
    pulse_start(8'h01);
    wait_frames(1, "rst");
    while (adc_bits < 7 && n < 500) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ss_n, sclk, sample_valid, overrun, busy, mosi} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failed++; $display("FAIL rst_mid_frame: got ss=%0b sclk=%0b v=%0b ov=%0b busy=%0b mosi=%0b required 1 1 0 0 0 0",
        ss_n, sclk, sample_valid, overrun, busy, mosi);
    end
    reset = 1'b0;
    sample_ready = 1'b1;
    mark();
    pulse_start(8'h01);
    wait_idle("rst_post");
    @(negedge clk);
    tests_run++;
    if (samp_q.size() - s_base != 1) begin failed++; $display("FAIL rst_restart_n: got %0d required 1", samp_q.size() - s_base); end
    else begin
      tests_run++;
      if (samp_q[s_base] !== {3'd0, 12'h100}) begin failed++; $display("FAIL rst_restart_data: got %h required %h", samp_q[s_base], {3'd0, 12'h100}); end
    end
  endtask

  task automatic test_res8();
    int n = 0;
    sel8 = 1'b1; force_en = 1'b1; force_word = 16'h0ABC;
    @(negedge clk); chan_mask = 8'h01; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    while (!sample_valid8 && n < 1000) begin @(negedge clk); n++; end
    tests_run++;
    if ({sample_valid8, sample_chan8, sample_data8} !== {1'b1, 3'd0, 8'hAB}) begin
      failed++; $display("FAIL res8_data: got v=%0b ch=%0d d=%h required 1 0 ab", sample_valid8, sample_chan8, sample_data8);
    end
    n = 0;
    while (busy8 && n < 1000) begin @(negedge clk); n++; end
    tests_run++;
    if (busy8 !== 1'b0 || ss_n8 !== 1'b1) begin failed++; $display("FAIL res8_idle: got busy=%0b ss=%0b required 0 1", busy8, ss_n8); end
    force_en = 1'b0; sel8 = 1'b0;
  endtask

  initial begin
    tests_run = 0; failed = 0;
    reset = 1'b1; start = 1'b0; start8 = 1'b0; continuous = 1'b0;
    chan_mask = 8'h00; sample_ready = 1'b1; overrun_clr = 1'b0;
    test_reset();
    test_single_scan();
    test_backpressure();
    test_continuous();
    test_mask_edge();
    test_reset_mid_frame();
    test_res8();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
